// File: rtl/reflet_bus_arbiter.sv
// reflet_bus_arbiter: shares one bus between two reflet masters (round-robin with quantum, lock, dead switch cycle).
// Define REFLET_ARBITER_FIXED_PRIORITY_EN to give master 0 fixed priority instead.
module reflet_bus_arbiter #(
  parameter int WORDSIZE = 16,
  parameter int QUANTUM  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                m0_req_i,
  input  logic                m0_lock_i,
  input  logic [WORDSIZE-1:0] m0_addr_i,
  input  logic [WORDSIZE-1:0] m0_data_out_i,
  input  logic                m0_write_en_i,
  output logic                m0_enable_o,
  input  logic                m1_req_i,
  input  logic                m1_lock_i,
  input  logic [WORDSIZE-1:0] m1_addr_i,
  input  logic [WORDSIZE-1:0] m1_data_out_i,
  input  logic                m1_write_en_i,
  output logic                m1_enable_o,
  output logic [WORDSIZE-1:0] bus_addr_o,
  output logic [WORDSIZE-1:0] bus_data_out_o,
  output logic                bus_write_en_o,
  output logic [1:0]          owner_o
);
  localparam int CW = $clog2(QUANTUM + 1);
  localparam logic [CW-1:0] QMAX = CW'(QUANTUM);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, SWITCH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d, count_sat;
  logic last_q, last_d;
  logic grant0, grant1, rel0, rel1, own0, own1;
`ifdef REFLET_ARBITER_FIXED_PRIORITY_EN
  assign grant0 = m0_req_i;
  assign grant1 = m1_req_i && !m0_req_i;
  assign rel0   = !m0_req_i;
  assign rel1   = !m1_req_i || (m0_req_i && !m1_lock_i);
`else
  localparam logic [CW-1:0] QM1 = CW'(QUANTUM - 1);
  logic expired;
  // expired means count reaches the quantum at this edge
  assign expired = count_q >= QM1;
  assign grant0  = m0_req_i && (!m1_req_i || last_q);
  assign grant1  = m1_req_i && (!m0_req_i || !last_q);
  assign rel0    = !m0_req_i || (expired && m1_req_i && !m0_lock_i);
  assign rel1    = !m1_req_i || (expired && m0_req_i && !m1_lock_i);
`endif
  assign count_sat = count_q == QMAX ? count_q : count_q + 1'b1;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    if (enable_i) begin
      case (state_q)
        OWN0: begin
          count_d = count_sat;
          state_d = rel0 ? SWITCH : OWN0;
        end
        OWN1: begin
          count_d = count_sat;
          state_d = rel1 ? SWITCH : OWN1;
        end
        default: begin
          count_d = '0;
          state_d = grant0 ? OWN0 : grant1 ? OWN1 : IDLE;
          last_d  = grant0 ? 1'b0 : grant1 ? 1'b1 : last_q;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end
  assign own0           = state_q == OWN0;
  assign own1           = state_q == OWN1;
  assign owner_o        = {own1, own0};
  assign m0_enable_o    = own0 && enable_i;
  assign m1_enable_o    = own1 && enable_i;
  assign bus_addr_o     = own0 ? m0_addr_i : own1 ? m1_addr_i : '0;
  assign bus_data_out_o = own0 ? m0_data_out_i : own1 ? m1_data_out_i : '0;
  assign bus_write_en_o = own0 ? m0_write_en_i : own1 ? m1_write_en_i : 1'b0;
endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// tb_reflet_bus_arbiter: directed scoreboard bench for reflet_bus_arbiter (default round-robin build).
module tb_reflet_bus_arbiter;
  logic clk, rst_n, enable;
  logic m0_req, m0_lock, m0_we, m0_en, m1_req, m1_lock, m1_we, m1_en, bus_we;
  logic [15:0] m0_addr, m0_data, m1_addr, m1_data, bus_addr, bus_data;
  logic [1:0] owner;
  typedef struct {
    string tag;
    logic [35:0] v;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  reflet_bus_arbiter #(.WORDSIZE(16), .QUANTUM(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .m0_req_i(m0_req), .m0_lock_i(m0_lock), .m0_addr_i(m0_addr), .m0_data_out_i(m0_data),
    .m0_write_en_i(m0_we), .m0_enable_o(m0_en),
    .m1_req_i(m1_req), .m1_lock_i(m1_lock), .m1_addr_i(m1_addr), .m1_data_out_i(m1_data),
    .m1_write_en_i(m1_we), .m1_enable_o(m1_en),
    .bus_addr_o(bus_addr), .bus_data_out_o(bus_data), .bus_write_en_o(bus_we), .owner_o(owner)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [35:0] expect_for(input logic [1:0] own);
    logic [15:0] a, d;
    logic w;
    a = own == 2'b01 ? m0_addr : own == 2'b10 ? m1_addr : 16'h0;
    d = own == 2'b01 ? m0_data : own == 2'b10 ? m1_data : 16'h0;
    w = own == 2'b01 ? m0_we : own == 2'b10 ? m1_we : 1'b0;
    return {own, own[0] & enable, own[1] & enable, a, d, w};
  endfunction
  task automatic step(input string tag, input logic [1:0] own, input bit clocked = 1);
    exp_t e;
    logic [35:0] obs;
    sb.push_back('{tag, expect_for(own)});
    if (clocked) @(posedge clk);
    #1;
    e = sb.pop_front();
    obs = {owner, m0_en, m1_en, bus_addr, bus_data, bus_we};
    n_vec++;
    assert (obs === e.v) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", e.tag, obs, e.v);
    end
  endtask
  initial begin
    rst_n = 1'b0; enable = 1'b1;
    m0_req = 1'b1; m0_lock = 1'b0; m0_we = 1'b0; m0_addr = 16'h1234; m0_data = 16'hAAAA;
    m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0; m1_addr = 16'h5678; m1_data = 16'h5555;
    step("reset_idle", 2'b00);
    rst_n = 1'b1;
    step("grant0", 2'b01);
    m1_req = 1'b1; m1_we = 1'b1;
    for (int i = 0; i < 15; i++) step("rr_own0", 2'b01);
    step("rr_switch_a", 2'b00);
    for (int i = 0; i < 16; i++) step("rr_own1", 2'b10);
    step("rr_switch_b", 2'b00);
    step("rr_back0", 2'b01);
    m0_lock = 1'b1;
    for (int i = 0; i < 39; i++) step("lock_hold", 2'b01);
    m0_lock = 1'b0;
    step("lock_drop_switch", 2'b00);
    step("lock_drop_own1", 2'b10);
    m0_req = 1'b0;
    for (int i = 0; i < 100; i++) step("solo_own1", 2'b10);
    m1_req = 1'b0;
    step("solo_release_switch", 2'b00);
    step("solo_idle", 2'b00);
    m0_req = 1'b1;
    step("idle_grant0", 2'b01);
    for (int i = 0; i < 7; i++) step("pre_freeze", 2'b01);
    enable = 1'b0; m1_req = 1'b1;
    for (int i = 0; i < 5; i++) step("frozen", 2'b01);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) step("resume", 2'b01);
    step("resume_switch", 2'b00);
    step("resume_own1", 2'b10);
    m1_req = 1'b0;
    step("drop_switch", 2'b00);
    m1_req = 1'b1;
    step("rerequest_loses", 2'b01);
    m0_we = 1'b1;
    step("own0_write", 2'b01, 0);
    #2 rst_n = 1'b0;
    step("async_reset", 2'b00, 0);
    step("held_reset", 2'b00);
    rst_n = 1'b1;
    step("reset_tie_m0", 2'b01);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
